// File: rtl/ka26_fold_ctrl.sv
// 26x26 carry-less multiplier that folds one 13-bit Karatsuba core over three cycles.
// The LO, HI and MID sub-products are XOR-accumulated into a 51-bit result with a 13-bit overlap.

module KA_13bit (
   input  logic [12:0] a,
   input  logic [12:0] b,
   output logic [24:0] p
);

   function automatic logic [12:0] clmul7(input logic [6:0] x, input logic [6:0] y);
      logic [12:0] r;
      r = '0;
      for (int i = 0; i < 7; i++) begin
         if (y[i]) r = r ^ ({6'b0, x} << i);
      end
      return r;
   endfunction

   logic [12:0] pl;
   logic [12:0] ph;
   logic [12:0] pm;

   // One Karatsuba level inside the core: a 7-bit low half and a 6-bit high half.
   always_comb begin
      pl = clmul7(a[6:0], b[6:0]);
      ph = clmul7({1'b0, a[12:7]}, {1'b0, b[12:7]});
      pm = clmul7(a[6:0] ^ {1'b0, a[12:7]}, b[6:0] ^ {1'b0, b[12:7]});
      p  = {12'b0, pl} ^ ({12'b0, pl ^ ph ^ pm} << 7) ^ ({12'b0, ph} << 14);
   end

endmodule

module ka26_fold_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [25:0] a,
   input  logic [25:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [50:0] y,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, LO, HI, MID, DONE} state_t;

   state_t      state_q, state_d;
   logic [25:0] a_q, a_d;
   logic [25:0] b_q, b_d;
   logic [50:0] acc_q, acc_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;

   logic [12:0] ka_a;
   logic [12:0] ka_b;
   logic [24:0] p;
   logic [50:0] p_ext;
   logic        accept;

   KA_13bit u_ka (
      .a (ka_a),
      .b (ka_b),
      .p (p)
   );

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign y         = acc_q;
   assign p_ext     = {26'b0, p};

   always_comb begin
      ka_a        = '0;
      ka_b        = '0;
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      case (state_q)
         LO: begin
            ka_a = a_q[12:0];
            ka_b = b_q[12:0];
         end
         HI: begin
            ka_a = a_q[25:13];
            ka_b = b_q[25:13];
         end
         MID: begin
            ka_a = a_q[12:0] ^ a_q[25:13];
            ka_b = b_q[12:0] ^ b_q[25:13];
         end
         default: ;
      endcase

      // LO overwrites acc, so no explicit clear is needed between products.
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = LO;
               a_d     = a;
               b_d     = b;
            end
         end
         LO: begin
            acc_d   = p_ext ^ (p_ext << 13);
            state_d = HI;
         end
         HI: begin
            acc_d   = acc_q ^ (p_ext << 13) ^ (p_ext << 26);
            state_d = MID;
         end
         MID: begin
            acc_d   = acc_q ^ (p_ext << 13);
            state_d = DONE;
         end
         DONE: begin
            if (accept) begin
               state_d = LO;
               a_d     = a;
               b_d     = b;
            end else if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == DONE);
      busy_d      = (state_d == LO) || (state_d == HI) || (state_d == MID);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_ka26_fold_ctrl.sv
// Directed bench for ka26_fold_ctrl: hand-computed products, backpressure, reset cases,
// followed by a randomized stall run checked against a bitwise carry-less model.

module tb_ka26_fold_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [25:0] a = '0;
   logic [25:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [50:0] y;
   logic        busy;

   int passCount = 0;
   int checkCount = 0;

   logic [50:0] expQ[$];
   int sent = 0;
   int recv = 0;

   ka26_fold_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [50:0] clmulRef(input logic [25:0] x, input logic [25:0] z);
      logic [50:0] r;
      r = '0;
      for (int i = 0; i < 26; i++) begin
         if (z[i]) r = r ^ ({25'b0, x} << i);
      end
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [50:0] obs, input logic [50:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input string tag, input logic [25:0] av, input logic [25:0] bv);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      #1;
      checkOutput({tag, "_in_ready"}, {50'b0, in_ready}, 51'd1);
      tick();
      in_valid = 1'b0;
      a        = ~av;
      b        = ~bv;
   endtask

   task automatic runDirected(input string tag, input logic [25:0] av, input logic [25:0] bv,
                              input logic [50:0] exp);
      applyStimulus(tag, av, bv);
      checkOutput({tag, "_busy"}, {50'b0, busy}, 51'd1);
      tick();
      tick();
      checkOutput({tag, "_early_valid"}, {50'b0, out_valid}, 51'd0);
      tick();
      checkOutput({tag, "_valid"}, {50'b0, out_valid}, 51'd1);
      checkOutput({tag, "_y"}, y, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({tag, "_valid_drop"}, {50'b0, out_valid}, 51'd0);
      checkOutput({tag, "_y_hold"}, y, exp);
   endtask

   initial begin
      // Asynchronous reset before any clock edge.
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_y", y, 51'd0);
      checkOutput("rst_out_valid", {50'b0, out_valid}, 51'd0);
      checkOutput("rst_busy", {50'b0, busy}, 51'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkOutput("rst_in_ready", {50'b0, in_ready}, 51'd1);
      tick();

      runDirected("lo_3x3", 26'h3, 26'h3, 51'h5);
      runDirected("lo_all1", 26'h3FFFFFF, 26'h1, 51'h3FFFFFF);
      runDirected("x13_sq", 26'h2000, 26'h2000, 51'h4000000);
      runDirected("x25_sq", 26'h2000000, 26'h2000000, 51'h4_0000_0000_0000);
      runDirected("x13p1_sq", 26'h2001, 26'h2001, 51'h4000001);

      // Backpressure: hold DONE for five cycles, then accept back-to-back.
      applyStimulus("bp", 26'h3, 26'h2000);
      tick();
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", {50'b0, out_valid}, 51'd1);
         checkOutput("bp_y", y, 51'h6000);
         checkOutput("bp_in_ready", {50'b0, in_ready}, 51'd0);
         tick();
      end
      a         = 26'h5;
      b         = 26'h5;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      checkOutput("b2b_in_ready", {50'b0, in_ready}, 51'd1);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 26'h3FFFFFF;
      b         = 26'h3FFFFFF;
      checkOutput("b2b_busy", {50'b0, busy}, 51'd1);
      checkOutput("b2b_valid_drop", {50'b0, out_valid}, 51'd0);
      tick();
      tick();
      tick();
      checkOutput("b2b_valid", {50'b0, out_valid}, 51'd1);
      checkOutput("b2b_y", y, 51'h11);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset asserted mid-cycle while in HI.
      applyStimulus("midrst", 26'h1FFF, 26'h1FFF);
      tick();
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_y", y, 51'd0);
      checkOutput("midrst_valid", {50'b0, out_valid}, 51'd0);
      checkOutput("midrst_busy", {50'b0, busy}, 51'd0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("midrst_in_ready", {50'b0, in_ready}, 51'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("midrst_no_valid", {50'b0, out_valid}, 51'd0);
      end
      runDirected("after_rst", 26'h1, 26'h1, 51'h1);

      // Reset coinciding with an accept drops the operands.
      a        = 26'h3;
      b        = 26'h3;
      in_valid = 1'b1;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("rstacc_busy", {50'b0, busy}, 51'd0);
         checkOutput("rstacc_valid", {50'b0, out_valid}, 51'd0);
         tick();
      end

      // Randomized traffic with random consumer stalls.
      for (int cyc = 0; cyc < 20000 && sent < 300; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = 26'($urandom);
         b         = 26'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (in_valid && in_ready) begin
            expQ.push_back(clmulRef(a, b));
            sent++;
         end
         if (out_valid && out_ready) begin
            checkOutput("rand_q_nonempty", {50'b0, expQ.size() != 0}, 51'd1);
            if (expQ.size() != 0) checkOutput("rand_y", y, expQ.pop_front());
            recv++;
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && recv < sent; cyc++) begin
         #1;
         if (out_valid) begin
            checkOutput("drain_q_nonempty", {50'b0, expQ.size() != 0}, 51'd1);
            if (expQ.size() != 0) checkOutput("drain_y", y, expQ.pop_front());
            recv++;
         end
         @(posedge clk);
         #1;
      end
      checkOutput("rand_sent", 51'(sent), 51'd300);
      checkOutput("rand_in_eq_out", 51'(recv), 51'(sent));

      $display("[TB] done");
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
